// File: rtl/pwm_audio_mc_if.sv
// Sample stream port for pwm_audio_mc: valid/ready handshake
// carrying a channel tag and an unsigned sample.
interface pwm_audio_mc_if #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2
);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             valid;
    logic             ready;
    logic [CHW-1:0]   chan;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output chan,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  chan,
        input  data,
        output ready
    );
endinterface

// File: rtl/pwm_audio_mc.sv
// Multi-channel PWM audio DAC with per-channel double buffering.
// Define PWM_AUDIO_SDM_EN to add the first-order delta-sigma mode.
module pwm_audio_mc #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2,
    parameter int PERIOD   = 4095
) (
    input  logic                clk,
    input  logic                rst,
    pwm_audio_mc_if.slave       s,
    input  logic                mode,
    output logic                frame_start,
    output logic [CHANNELS-1:0] underrun,
    output logic [CHANNELS-1:0] pwm_out
);
    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW   = $clog2(PERIOD);
    localparam int CMPW = (WIDTH > CW) ? WIDTH : CW;

    localparam logic [CW-1:0]    LAST = CW'(PERIOD - 1);
    localparam logic [CHW:0]     NCH  = (CHW + 1)'(CHANNELS);
    localparam logic [WIDTH-1:0] MID  = {1'b1, {(WIDTH - 1){1'b0}}};

    logic [CW-1:0]       count;
    logic                boundary;
    logic                in_range;
    logic                accept;
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];
    logic [CHANNELS-1:0] shadow_full;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] pwm_bit;
    logic [CHANNELS-1:0] next_out;

    assign boundary = (count == LAST);
    assign in_range = ({1'b0, s.chan} < NCH);
    // Out-of-range channels are always ready so they drain and vanish.
    assign s.ready  = in_range ? !shadow_full[s.chan] : 1'b1;
    assign accept   = s.valid && s.ready && in_range;

    always_comb begin
        hit     = '0;
        pwm_bit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hit[c]     = accept && (s.chan == CHW'(c));
            pwm_bit[c] = CMPW'(count) < CMPW'(active[c]);
        end
    end

`ifdef PWM_AUDIO_SDM_EN
    logic                mode_q;
    logic [WIDTH-1:0]    acc [CHANNELS];
    logic [WIDTH:0]      sum [CHANNELS];
    logic [CHANNELS-1:0] sdm_bit;

    always_comb begin
        sdm_bit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum[c]     = {1'b0, acc[c]} + {1'b0, active[c]};
            sdm_bit[c] = sum[c][WIDTH];
        end
    end

    // The carry lives in pwm_out, so acc keeps only the low bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            if (boundary) begin
                mode_q <= mode;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (boundary && (mode != mode_q)) begin
                    acc[c] <= '0;
                end else begin
                    acc[c] <= sum[c][WIDTH-1:0];
                end
            end
        end
    end

    assign next_out = mode_q ? sdm_bit : pwm_bit;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign next_out    = pwm_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            frame_start <= 1'b0;
            shadow_full <= '0;
            underrun    <= '0;
            pwm_out     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow[c] <= '0;
                active[c] <= MID;
            end
        end else begin
            count       <= boundary ? '0 : count + 1'b1;
            frame_start <= (count == '0);
            pwm_out     <= next_out;
            for (int c = 0; c < CHANNELS; c++) begin
                if (hit[c]) begin
                    shadow[c]      <= s.data;
                    shadow_full[c] <= 1'b1;
                end
                if (boundary && shadow_full[c]) begin
                    active[c]      <= shadow[c];
                    shadow_full[c] <= 1'b0;
                end
                // A starved boundary outranks a same-cycle refill.
                if (boundary && !shadow_full[c]) begin
                    underrun[c] <= 1'b1;
                end else if (hit[c]) begin
                    underrun[c] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_audio_mc.sv
// Directed bench for pwm_audio_mc at WIDTH=8, PERIOD=200,
// so midscale is 128 and samples >= 200 saturate high.
module tb_pwm_audio_mc;
    localparam int W  = 8;
    localparam int CH = 2;
    localparam int P  = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic          frame_start;
    logic [CH-1:0] underrun;
    logic [CH-1:0] pwm_out;

    int total = 0;
    int bad   = 0;

    pwm_audio_mc_if #(.WIDTH(W), .CHANNELS(CH)) s_if ();

    pwm_audio_mc #(
        .WIDTH(W),
        .CHANNELS(CH),
        .PERIOD(P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s(s_if),
        .mode(mode),
        .frame_start(frame_start),
        .underrun(underrun),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic measure(output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        for (int i = 0; i < P; i++) begin
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            @(negedge clk);
        end
    endtask

    task automatic put(input int ch, input int d, output int waits);
        s_if.chan  = 1'(ch);
        s_if.data  = W'(d);
        s_if.valid = 1'b1;
        waits = 0;
        #1;
        while (!s_if.ready && waits < 3 * P) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        s_if.valid = 1'b0;
    endtask

    task automatic test_reset;
        bit ok;
        int h0, h1;
        s_if.valid = 1'b0;
        s_if.chan  = 1'b0;
        s_if.data  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (pwm_out !== 2'b00) begin
            bad++;
            $display("FAIL reset_pwm got=%b exp=00", pwm_out);
        end
        total++;
        if (s_if.ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", s_if.ready);
        end
        total++;
        if (underrun !== 2'b00) begin
            bad++;
            $display("FAIL reset_underrun got=%b exp=00", underrun);
        end
        total++;
        if (frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_fs got=%b exp=0", frame_start);
        end
        wait_frame(ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL reset_frame got=%b exp=1", ok);
        end
        measure(h0, h1);
        total++;
        if (h0 != 128 || h1 != 128) begin
            bad++;
            $display("FAIL reset_duty got=%0d/%0d exp=128/128", h0, h1);
        end
    endtask

    task automatic test_pwm;
        int h0, h1, w;
        fork
            measure(h0, h1);
            begin
                put(0, 100, w);
                put(1, 0, w);
            end
        join
        total++;
        if (h0 != 128 || h1 != 128) begin
            bad++;
            $display("FAIL pwm_mid got=%0d/%0d exp=128/128", h0, h1);
        end
        fork
            measure(h0, h1);
            put(0, 255, w);
        join
        total++;
        if (h0 != 100 || h1 != 0) begin
            bad++;
            $display("FAIL pwm_100_0 got=%0d/%0d exp=100/0", h0, h1);
        end
        measure(h0, h1);
        total++;
        if (h0 != 200 || h1 != 0) begin
            bad++;
            $display("FAIL pwm_sat got=%0d/%0d exp=200/0", h0, h1);
        end
    endtask

    task automatic test_back_to_back;
        int h0, h1, w;
        put(0, 100, w);
        total++;
        if (w != 0) begin
            bad++;
            $display("FAIL b2b_first got=%0d exp=0", w);
        end
        s_if.chan = 1'b0;
        #1;
        total++;
        if (s_if.ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready0 got=%b exp=0", s_if.ready);
        end
        s_if.chan = 1'b1;
        #1;
        total++;
        if (s_if.ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready1 got=%b exp=1", s_if.ready);
        end
        put(1, 200, w);
        total++;
        if (w != 0) begin
            bad++;
            $display("FAIL b2b_ch1 got=%0d exp=0", w);
        end
        put(0, 50, w);
        total++;
        if (w != 197) begin
            bad++;
            $display("FAIL b2b_stall got=%0d exp=197", w);
        end
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL b2b_align got=%b exp=1", frame_start);
        end
        measure(h0, h1);
        total++;
        if (h0 != 100 || h1 != 200) begin
            bad++;
            $display("FAIL b2b_f1 got=%0d/%0d exp=100/200", h0, h1);
        end
        measure(h0, h1);
        total++;
        if (h0 != 50 || h1 != 200) begin
            bad++;
            $display("FAIL b2b_f2 got=%0d/%0d exp=50/200", h0, h1);
        end
    endtask

    task automatic test_underrun;
        bit ok;
        int h0, h1, w;
        put(0, 60, w);
        put(1, 70, w);
        wait_frame(ok);
        total++;
        if (ok !== 1'b1 || underrun !== 2'b00) begin
            bad++;
            $display("FAIL ur_clear got=%b/%b exp=1/00", ok, underrun);
        end
        fork
            measure(h0, h1);
            put(0, 80, w);
        join
        total++;
        if (h0 != 60 || h1 != 70) begin
            bad++;
            $display("FAIL ur_f1 got=%0d/%0d exp=60/70", h0, h1);
        end
        total++;
        if (underrun !== 2'b10) begin
            bad++;
            $display("FAIL ur_set got=%b exp=10", underrun);
        end
        measure(h0, h1);
        total++;
        if (h0 != 80 || h1 != 70) begin
            bad++;
            $display("FAIL ur_repeat got=%0d/%0d exp=80/70", h0, h1);
        end
        repeat (P - 2) @(negedge clk);
        s_if.chan  = 1'b1;
        s_if.data  = W'(90);
        s_if.valid = 1'b1;
        #1;
        total++;
        if (s_if.ready !== 1'b1) begin
            bad++;
            $display("FAIL ur_bready got=%b exp=1", s_if.ready);
        end
        @(negedge clk);
        s_if.valid = 1'b0;
        total++;
        if (underrun !== 2'b11) begin
            bad++;
            $display("FAIL ur_wins got=%b exp=11", underrun);
        end
        put(1, 30, w);
        total++;
        if (w != 200) begin
            bad++;
            $display("FAIL ur_stall got=%0d exp=200", w);
        end
        total++;
        if (underrun !== 2'b01) begin
            bad++;
            $display("FAIL ur_next got=%b exp=01", underrun);
        end
        measure(h0, h1);
        total++;
        if (h0 != 80 || h1 != 90) begin
            bad++;
            $display("FAIL ur_late got=%0d/%0d exp=80/90", h0, h1);
        end
    endtask

    task automatic test_reset_mid;
        int h0, h1, w;
        put(0, 10, w);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_if.chan = 1'b0;
        #1;
        total++;
        if (s_if.ready !== 1'b1) begin
            bad++;
            $display("FAIL rm_ready0 got=%b exp=1", s_if.ready);
        end
        s_if.chan = 1'b1;
        #1;
        total++;
        if (s_if.ready !== 1'b1) begin
            bad++;
            $display("FAIL rm_ready1 got=%b exp=1", s_if.ready);
        end
        total++;
        if (pwm_out !== 2'b00 || underrun !== 2'b00) begin
            bad++;
            $display("FAIL rm_out got=%b/%b exp=00/00", pwm_out, underrun);
        end
        @(negedge clk);
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL rm_restart got=%b exp=1", frame_start);
        end
        measure(h0, h1);
        total++;
        if (h0 != 128 || h1 != 128) begin
            bad++;
            $display("FAIL rm_duty got=%0d/%0d exp=128/128", h0, h1);
        end
    endtask

`ifdef PWM_AUDIO_SDM_EN
    task automatic test_sdm;
        bit ok;
        int w, o0, o1;
        logic [7:0] pat;
        mode = 1'b1;
        put(0, 128, w);
        put(1, 1, w);
        wait_frame(ok);
        o0 = 0;
        o1 = 0;
        pat = '0;
        for (int i = 0; i < 256; i++) begin
            if (i < 8) begin
                pat[i] = pwm_out[0];
            end
            o0 += int'(pwm_out[0]);
            o1 += int'(pwm_out[1]);
            @(negedge clk);
        end
        mode = 1'b0;
        total++;
        if (ok !== 1'b1 || pat !== 8'haa) begin
            bad++;
            $display("FAIL sdm_pat got=%b/%h exp=1/aa", ok, pat);
        end
        total++;
        if (o0 != 128 || o1 != 1) begin
            bad++;
            $display("FAIL sdm_dens got=%0d/%0d exp=128/1", o0, o1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pwm();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
`ifdef PWM_AUDIO_SDM_EN
        test_sdm();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
